// File: rtl/mining_pkg.sv
//------------------------------------------------------------------------------
// Module  : mining_pkg
// Brief   : Shared state encoding and default widths for the nonce sequencer.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mining_pkg;

    localparam int HASH_W_DEF  = 256;
    localparam int NONCE_W_DEF = 32;
    localparam int DIFF_W_DEF  = 9;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mining_lzc.sv
//------------------------------------------------------------------------------
// Module  : mining_lzc
// Brief   : Combinational leading-zero count; an all-zero input yields HASH_W.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mining_lzc
    import mining_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF,
    parameter int DIFF_W = DIFF_W_DEF
) (
    input  logic [HASH_W-1:0] data_i,
    output logic [DIFF_W-1:0] count_o
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        count_o = DIFF_W'(HASH_W);
        for (int i = 0; i < HASH_W; i++) begin
            if (data_i[i]) begin
                count_o = DIFF_W'(HASH_W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mining_nonce_ctrl.sv
//------------------------------------------------------------------------------
// Module  : mining_nonce_ctrl
// Brief   : Sweeps a nonce range through a hash core and reports the first digest
//           meeting a runtime leading-zero difficulty, or range exhaustion.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mining_nonce_ctrl
    import mining_pkg::*;
#(
    parameter int HASH_W  = HASH_W_DEF,
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int DIFF_W  = DIFF_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [DIFF_W-1:0]  difficulty,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash,
    output logic [CNT_W-1:0]   attempts
);

    state_e             state_q,       state_d;
    logic [NONCE_W-1:0] nonce_q,       nonce_d;
    logic [NONCE_W-1:0] nonce_end_q,   nonce_end_d;
    logic [DIFF_W-1:0]  diff_q,        diff_d;
    logic [HASH_W-1:0]  hash_q,        hash_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [HASH_W-1:0]  found_hash_q,  found_hash_d;
    logic [CNT_W-1:0]   attempts_q,    attempts_d;

    logic [DIFF_W-1:0]  w_lzc;
    logic [DIFF_W-1:0]  w_thr;
    logic               w_hit;

    mining_lzc #(
        .HASH_W (HASH_W),
        .DIFF_W (DIFF_W)
    ) u_lzc (
        .data_i  (hash_q),
        .count_o (w_lzc)
    );

    // Difficulties beyond the digest width collapse to "all bits zero".
    assign w_thr = (diff_q > DIFF_W'(HASH_W)) ? DIFF_W'(HASH_W) : diff_q;
    assign w_hit = (w_lzc >= w_thr);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            nonce_q       <= '0;
            nonce_end_q   <= '0;
            diff_q        <= '0;
            hash_q        <= '0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            attempts_q    <= '0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            nonce_end_q   <= nonce_end_d;
            diff_q        <= diff_d;
            hash_q        <= hash_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            attempts_q    <= attempts_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        nonce_end_d   = nonce_end_q;
        diff_d        = diff_q;
        hash_d        = hash_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        attempts_d    = attempts_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        diff_d      = difficulty;
                        nonce_d     = nonce_start;
                        nonce_end_d = nonce_end;
                        attempts_d  = '0;
                        state_d     = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (core_done) begin
                        hash_d  = core_hash;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (attempts_q != '1) begin
                        attempts_d = attempts_q + 1'b1;
                    end
                    if (w_hit) begin
                        found_nonce_d = nonce_q;
                        found_hash_d  = hash_q;
                        state_d       = ST_FOUND;
                    end else if (nonce_q == nonce_end_q) begin
                        state_d = ST_EXHAUSTED;
                    end else begin
                        nonce_d = nonce_q + 1'b1;
                        state_d = ST_LAUNCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign core_start  = (state_q == ST_LAUNCH);
    assign core_nonce  = nonce_q;
    assign busy        = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign found       = (state_q == ST_FOUND);
    assign exhausted   = (state_q == ST_EXHAUSTED);
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign attempts    = attempts_q;

endmodule

`default_nettype wire

// File: tb/tb_mining_nonce_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_mining_nonce_ctrl
// Brief   : Self-checking bench: directed scenarios plus random sweeps against a
//           list-based reference of the sweep outcome.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mining_nonce_ctrl;

    localparam int L = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [8:0]   difficulty;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         core_start;
    logic [31:0]  core_nonce;
    logic         core_done;
    logic [255:0] core_hash;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic [31:0]  attempts;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    int            lz_map [logic [31:0]];
    int            default_lz;
    logic [31:0]   launched[$];
    int            launch_cyc[$];
    logic [31:0]   exp_seq[$];
    bit            exp_found;
    logic [31:0]   exp_nonce;
    int            exp_att;

    mining_nonce_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .difficulty  (difficulty),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .core_start  (core_start),
        .core_nonce  (core_nonce),
        .core_done   (core_done),
        .core_hash   (core_hash),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .attempts    (attempts)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lz_of(input logic [31:0] n);
        if (lz_map.exists(n)) return lz_map[n];
        return default_lz;
    endfunction

    // Digest with exactly lz_of(n) leading zeros (all zero when >= 256).
    function automatic logic [255:0] hash_of(input logic [31:0] n);
        int k;
        logic [255:0] p;
        k = lz_of(n);
        if (k >= 256) return '0;
        p = {8{n ^ 32'hDEADBEEF}};
        p = p >> (k + 1);
        p[255 - k] = 1'b1;
        return p;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the nonce list in order, first qualifying digest wins.
    task automatic predict(input logic [31:0] s, input logic [31:0] e, input int d);
        logic [31:0] n;
        int thr;
        thr = (d > 256) ? 256 : d;
        exp_seq.delete();
        exp_found = 1'b0;
        exp_nonce = '0;
        exp_att   = 0;
        n = s;
        for (int k = 0; k < 4096; k++) begin
            exp_seq.push_back(n);
            exp_att++;
            if (lz_of(n) >= thr) begin
                exp_found = 1'b1;
                exp_nonce = n;
                break;
            end
            if (n == e) break;
            n = n + 1;
        end
    endtask

    // Hash core model: done arrives L+1 cycles after the launch cycle.
    initial begin
        logic [31:0] n;
        core_done = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clock);
            if (core_start === 1'b1) begin
                n = core_nonce;
                launched.push_back(n);
                launch_cyc.push_back(cyc);
                repeat (L + 1) @(negedge clock);
                core_hash = hash_of(n);
                core_done = 1'b1;
                @(negedge clock);
                core_done = 1'b0;
            end
        end
    end

    task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                             input logic [8:0] d, input bit poke);
        int waited;
        predict(s, e, int'(d));
        launched.delete();
        launch_cyc.delete();
        @(negedge clock);
        start = 1'b1; nonce_start = s; nonce_end = e; difficulty = d;
        @(negedge clock);
        start = 1'b0; nonce_start = $urandom; nonce_end = $urandom; difficulty = 9'($urandom);
        if (poke) begin
            repeat (3) @(negedge clock);
            start = 1'b1; nonce_start = s + 100;
            @(negedge clock);
            start = 1'b0;
        end
        waited = 0;
        while (!(found === 1'b1 || exhausted === 1'b1) && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "/done"}, (found === 1'b1 || exhausted === 1'b1), 1);
        check({tag, "/found"}, found, exp_found);
        check({tag, "/exhausted"}, exhausted, !exp_found);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/attempts"}, attempts, exp_att);
        if (exp_found) begin
            check({tag, "/found_nonce"}, found_nonce, exp_nonce);
            check({tag, "/found_hash"}, found_hash, hash_of(exp_nonce));
        end
        check({tag, "/launches"}, launched.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < launched.size(); i++)
            check($sformatf("%s/nonce%0d", tag, i), launched[i], exp_seq[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] rs, re;
        logic [8:0]  rd;
        int len;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        difficulty = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(negedge clock);
        check("reset/core_start", core_start, 0);
        check("reset/busy", busy, 0);
        check("reset/found", found, 0);
        check("reset/exhausted", exhausted, 0);
        check("reset/attempts", attempts, 0);
        check("reset/found_nonce", found_nonce, 0);
        reset = 1'b0;

        // 1: hit in the middle of the range; start while busy must be ignored
        lz_map.delete(); default_lz = 3; lz_map[32'd15] = 8;
        run_sweep("t1", 32'd10, 32'd20, 9'd8, 1'b1);
        check("t1/nonce15", found_nonce, 15);
        check("t1/att6", attempts, 6);

        // 2: no qualifying digest, launch spacing 3+L
        lz_map.delete(); default_lz = 11;
        run_sweep("t2", 32'd0, 32'd3, 9'd12, 1'b0);
        check("t2/att4", attempts, 4);
        for (int i = 1; i < launch_cyc.size(); i++)
            check("t2/spacing", launch_cyc[i] - launch_cyc[i-1], 3 + L);

        // 3: wrap through all-ones
        lz_map.delete(); default_lz = 2;
        run_sweep("t3", 32'hFFFF_FFFE, 32'h0000_0001, 9'd12, 1'b0);

        // 4: difficulty 0 and difficulty beyond the digest width
        lz_map.delete(); default_lz = 0;
        run_sweep("t4a", 32'h1234_5678, 32'h1234_5690, 9'd0, 1'b0);
        check("t4a/att1", attempts, 1);
        lz_map.delete(); default_lz = 200; lz_map[32'd7] = 256;
        run_sweep("t4b", 32'd3, 32'd10, 9'd300, 1'b0);
        check("t4b/nonce7", found_nonce, 7);

        // 5: abort two cycles into WAIT, late core_done ignored
        lz_map.delete(); default_lz = 0;
        @(negedge clock);
        start = 1'b1; nonce_start = 32'd100; nonce_end = 32'd200; difficulty = 9'd20;
        @(negedge clock);
        start = 1'b0;
        w = 0;
        while (core_start !== 1'b1 && w < 50) begin @(negedge clock); w++; end
        check("t5/launch_seen", core_start, 1);
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t5/busy", busy, 0);
        check("t5/found", found, 0);
        check("t5/attempts", attempts, 0);
        repeat (3) @(negedge clock);
        check("t5/still_idle", {busy, found, exhausted, core_start}, 4'b0000);
        run_sweep("t5b", 32'd40, 32'd44, 9'd0, 1'b0);

        // 6: reset together with start while in CHECK
        @(negedge clock);
        start = 1'b1; nonce_start = 32'd5; nonce_end = 32'd9; difficulty = 9'd0;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("t6/in_check", busy, 1);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check("t6/outputs", {core_start, busy, found, exhausted}, 4'b0000);
        check("t6/core_nonce", core_nonce, 0);
        check("t6/found_nonce", found_nonce, 0);
        check("t6/found_hash", found_hash, 0);
        check("t6/attempts", attempts, 0);
        repeat (8) @(negedge clock);
        check("t6/idle_after", {core_start, busy}, 2'b00);

        // Random sweeps against the reference
        for (int it = 0; it < 10; it++) begin
            lz_map.delete();
            default_lz = $urandom_range(0, 4);
            rs  = $urandom;
            len = $urandom_range(0, 6);
            re  = rs + 32'(len);
            rd  = ($urandom_range(0, 9) == 0) ? 9'd300 : 9'($urandom_range(0, 24));
            for (int j = 0; j <= len; j++) begin
                if ($urandom_range(0, 3) == 0)
                    lz_map[rs + 32'(j)] = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(0, 30);
            end
            run_sweep($sformatf("rnd%0d", it), rs, re, rd, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
